// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with built-in load-use hazard detection.
// Optional HAZARD_STATS_EN adds a saturating count of inserted bubbles.
module id_ex_stage_register #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_read_data1,
  input  logic [DATA_W-1:0] id_read_data2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_reg_dst,
  input  logic              id_alu_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic [1:0]        id_alu_op,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_read_data1,
  output logic [DATA_W-1:0] ex_read_data2,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_reg_dst,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic [1:0]        ex_alu_op,
`ifdef HAZARD_STATS_EN
  output logic [31:0]       stall_count,
`endif
  output logic              pc_write,
  output logic              if_id_write,
  output logic              stall
);

  logic rt_nonzero;
  logic rt_match;
  logic hazard;
  logic squash;

  // A load in EX whose destination is read by ID cannot forward in time.
  always_comb begin
    rt_nonzero = (ex_rt != '0);
    rt_match   = (ex_rt == id_rs) || (ex_rt == id_rt);
    hazard     = ex_mem_read && rt_nonzero && rt_match && !flush;
    squash     = flush || hazard;
    stall       = hazard;
    pc_write    = !hazard;
    if_id_write = !hazard;
  end

  // Bubbles clear rd and reg_write so forwarding never sources from them.
  always_ff @(posedge clk) begin
    if (reset || squash) begin
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_read_data1 <= '0;
      ex_read_data2 <= '0;
      ex_imm        <= '0;
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_alu_op     <= 2'b00;
    end else begin
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
      ex_read_data1 <= id_read_data1;
      ex_read_data2 <= id_read_data2;
      ex_imm        <= id_imm;
      ex_reg_dst    <= id_reg_dst;
      ex_alu_src    <= id_alu_src;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_reg_write  <= id_reg_write;
      ex_alu_op     <= id_alu_op;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (hazard && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
